// File: rtl/matrix_pkg.sv
// Shared constants, irrigation state encodings and the 5x7 status glyph table.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package matrix_pkg;

    localparam int MATRIX_COLS = 5;
    localparam int MATRIX_ROWS = 7;
    localparam int COL_W       = $clog2(MATRIX_COLS);

    typedef enum logic [1:0] {
        ST_IDLE        = 2'b00,
        ST_GOTEJAMENTO = 2'b01,
        ST_ASPERSAO    = 2'b10
    } irr_state_e;

    // Active-low row image for one column; undefined state 11 shows the idle (dark) image.
    function automatic logic [MATRIX_ROWS-1:0] matrix_pattern(
        input logic [1:0]       state,
        input logic [COL_W-1:0] col
    );
        logic [MATRIX_ROWS-1:0] pat;
        pat = '1;
        case (state)
            ST_ASPERSAO: begin
                case (col)
                    3'd0, 3'd4: pat = 7'b0111001;
                    3'd1, 3'd3: pat = 7'b0011110;
                    3'd2:       pat = 7'b0000000;
                    default:    pat = '1;
                endcase
            end
            ST_GOTEJAMENTO: begin
                case (col)
                    3'd0, 3'd4: pat = 7'b1001111;
                    3'd1, 3'd3: pat = 7'b0000011;
                    3'd2:       pat = 7'b0000001;
                    default:    pat = '1;
                endcase
            end
            default: pat = '1;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/matrix_scan_driver_if.sv
// Control inputs and matrix pin drive of the scan driver, bundled for port lists.
// Latency: n/a (wiring only).
// Backpressure: none; the driver free-runs and the pins are sampled by nothing.
interface matrix_scan_driver_if;
    import matrix_pkg::*;

    logic                   enable;
    logic [1:0]             state;
    logic                   blink;
    logic [MATRIX_COLS-1:0] col_sel;
    logic [MATRIX_ROWS-1:0] row_n;
    logic                   frame_start;

    // Master is the irrigation controller side, slave is the scan driver.
    modport master (output enable, state, blink, input col_sel, row_n, frame_start);
    modport slave  (input enable, state, blink, output col_sel, row_n, frame_start);

endinterface

// File: rtl/matrix_scan_timer.sv
// Slot prescaler and column counter; emits slot_start, blank and frame_wrap strobes.
// Latency: strobes are combinational from the counter registers (same cycle).
// Backpressure: none; enable low holds both counters at zero.
module matrix_scan_timer
    import matrix_pkg::*;
#(
    parameter int CLK_DIV     = 50000,
    parameter int DEAD_CYCLES = 16,
    parameter int PRESC_W     = $clog2(CLK_DIV)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    output logic [COL_W-1:0] col_idx,
    output logic             slot_start,
    output logic             blank,
    output logic             frame_wrap
);

    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [COL_W-1:0]   col_idx_q, col_idx_d;
    logic               presc_last;

    assign presc_last = (presc_q == PRESC_W'(CLK_DIV - 1));

    // Prescaler wraps every CLK_DIV cycles and steps the column; enable low clears both.
    always_comb begin
        presc_d   = presc_q;
        col_idx_d = col_idx_q;
        if (!enable) begin
            presc_d   = '0;
            col_idx_d = '0;
        end else if (presc_last) begin
            presc_d   = '0;
            col_idx_d = (col_idx_q == COL_W'(MATRIX_COLS - 1)) ? '0 : col_idx_q + COL_W'(1);
        end else begin
            presc_d = presc_q + PRESC_W'(1);
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q   <= '0;
            col_idx_q <= '0;
        end else begin
            presc_q   <= presc_d;
            col_idx_q <= col_idx_d;
        end
    end

    assign col_idx    = col_idx_q;
    assign slot_start = (presc_q == '0);
    // Counters sit at zero after reset and while disabled, so the first enabled
    // cycle and every 4->0 column wrap both land here.
    assign frame_wrap = enable && slot_start && (col_idx_q == '0);

    // Dead-time comparison only exists when there is dead time to mark.
    if (DEAD_CYCLES == 0) begin : g_no_dead
        assign blank = 1'b0;
    end else begin : g_dead
        assign blank = (presc_q < PRESC_W'(DEAD_CYCLES));
    end

endmodule

// File: rtl/matrix_scan_driver.sv
// Column-scanned 5x7 LED drive of the irrigation state, image latched per frame; MATRIX_BLINK_EN adds frame blinking.
// Latency: outputs registered, one clock after the counter/state decode.
// Backpressure: none; enable low blanks the pins and restarts the scan at column 0.
module matrix_scan_driver
    import matrix_pkg::*;
#(
    parameter int CLK_DIV      = 50000,
    parameter int DEAD_CYCLES  = 16,
    parameter int BLINK_FRAMES = 25
) (
    input  logic                clk,
    input  logic                rst_n,
    matrix_scan_driver_if.slave bus
);

    localparam int PRESC_W = $clog2(CLK_DIV);

    logic [COL_W-1:0]       col_idx;
    logic                   slot_start;
    logic                   blank;
    logic                   frame_wrap;

    logic [1:0]             state_q, state_d;
    logic                   blink_q, blink_d;
    logic                   frame_off;

    logic [MATRIX_COLS-1:0] col_sel_q, col_sel_d;
    logic [MATRIX_ROWS-1:0] row_n_q, row_n_d;
    logic                   frame_start_q, frame_start_d;

    logic                   unused_sink;

    matrix_scan_timer #(
        .CLK_DIV     (CLK_DIV),
        .DEAD_CYCLES (DEAD_CYCLES),
        .PRESC_W     (PRESC_W)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (bus.enable),
        .col_idx    (col_idx),
        .slot_start (slot_start),
        .blank      (blank),
        .frame_wrap (frame_wrap)
    );

    // Sample the requested image only at frame boundaries so a frame never tears.
    always_comb begin
        state_d = state_q;
        blink_d = blink_q;
        if (frame_wrap) begin
            state_d = bus.state;
            blink_d = bus.blink;
        end
    end

`ifdef MATRIX_BLINK_EN
    localparam int FCNT_W = $clog2(2 * BLINK_FRAMES);

    logic [FCNT_W-1:0] fcnt_q, fcnt_d;
    logic              off_q, off_d;

    // Frame counter: first BLINK_FRAMES frames of a blink run are lit, the next
    // BLINK_FRAMES dark; a boundary that sees blink low restarts on the lit phase.
    always_comb begin
        fcnt_d = fcnt_q;
        off_d  = off_q;
        if (!bus.enable) begin
            fcnt_d = '0;
            off_d  = 1'b0;
        end else if (frame_wrap) begin
            off_d = bus.blink && (fcnt_q >= FCNT_W'(BLINK_FRAMES));
            if (!bus.blink || (fcnt_q == FCNT_W'(2 * BLINK_FRAMES - 1))) begin
                fcnt_d = '0;
            end else begin
                fcnt_d = fcnt_q + FCNT_W'(1);
            end
        end
    end

    // Blink phase registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fcnt_q <= '0;
            off_q  <= 1'b0;
        end else begin
            fcnt_q <= fcnt_d;
            off_q  <= off_d;
        end
    end

    assign frame_off = off_d;
`else
    assign frame_off = 1'b0;
`endif

    // blink_q is kept for observability; slot_start is not needed by the decode.
    assign unused_sink = blink_q ^ slot_start ^ (BLINK_FRAMES == 0);

    // Pin decode. state_d/frame_off carry the freshly sampled frame values on the
    // boundary cycle, so slot 0 of column 0 already shows the new image when
    // there is no dead time.
    always_comb begin
        col_sel_d     = '0;
        row_n_d       = '1;
        frame_start_d = 1'b0;
        if (bus.enable) begin
            frame_start_d = frame_wrap;
            if (!blank && !frame_off) begin
                col_sel_d = MATRIX_COLS'(1) << col_idx;
                row_n_d   = matrix_pattern(state_d, col_idx);
            end
        end
    end

    // Latched frame image and registered pin drive; reset blanks the pins at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            blink_q       <= 1'b0;
            col_sel_q     <= '0;
            row_n_q       <= '1;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            blink_q       <= blink_d;
            col_sel_q     <= col_sel_d;
            row_n_q       <= row_n_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign bus.col_sel     = col_sel_q;
    assign bus.row_n       = row_n_q;
    assign bus.frame_start = frame_start_q;

endmodule

// File: tb/tb_matrix_scan_driver.sv
// Scoreboard bench for matrix_scan_driver with CLK_DIV=8, DEAD_CYCLES=2, BLINK_FRAMES=2.
// Expected pin values are queued per absolute cycle ahead of time; a monitor compares on each falling edge.
// Follows MATRIX_BLINK_EN so the blink frames are expected dark only when the feature is built.
module tb_matrix_scan_driver;
    import matrix_pkg::*;

    typedef struct {
        int       cyc;
        logic [4:0] col;
        logic [6:0] row;
        logic       fs;
    } exp_t;

    exp_t exp_q[$];
    exp_t m;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    bit   blink_en;

    matrix_scan_driver_if bus();

    matrix_scan_driver #(
        .CLK_DIV      (8),
        .DEAD_CYCLES  (2),
        .BLINK_FRAMES (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Hand-written glyph table (row_n, active low) for cols 0..4.
    function automatic logic [6:0] exp_row(input int st, input int c);
        logic [6:0] r;
        r = 7'b1111111;
        if (st == 2) begin
            if (c == 0 || c == 4)      r = 7'b0111001;
            else if (c == 1 || c == 3) r = 7'b0011110;
            else                       r = 7'b0000000;
        end else if (st == 1) begin
            if (c == 0 || c == 4)      r = 7'b1001111;
            else if (c == 1 || c == 3) r = 7'b0000011;
            else                       r = 7'b0000001;
        end
        return r;
    endfunction

    // Frame slice: index i = col*8 + slot cycle; cycles 0,1 of each slot are dark.
    task automatic push_range(input int base, input int st, input bit off, input int lo, input int hi);
        exp_t e;
        for (int i = lo; i <= hi; i++) begin
            int c;
            int p;
            c = i / 8;
            p = i % 8;
            e.cyc = base + i;
            e.fs  = (i == 0);
            if (!off && p >= 2) begin
                e.col = 5'(1 << c);
                e.row = exp_row(st, c);
            end else begin
                e.col = 5'b00000;
                e.row = 7'b1111111;
            end
            exp_q.push_back(e);
        end
    endtask

    task automatic push_frame(input int base, input int st, input bit off);
        push_range(base, st, off, 0, 39);
    endtask

    task automatic push_blank(input int lo, input int hi);
        exp_t e;
        for (int k = lo; k <= hi; k++) begin
            e.cyc = k;
            e.col = 5'b00000;
            e.row = 7'b1111111;
            e.fs  = 1'b0;
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Monitor: compare the pins against the entry scheduled for this cycle.
    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            m = exp_q.pop_front();
            n_chk++;
            n_fail++;
            $display("FAIL missed_sample cyc=%0d: no sample taken, required one at cyc %0d", cyc, m.cyc);
        end
        if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
            m = exp_q.pop_front();
            n_chk++;
            if (bus.col_sel !== m.col || bus.row_n !== m.row || bus.frame_start !== m.fs) begin
                n_fail++;
                $display("FAIL scan cyc=%0d: got col_sel=%b row_n=%b frame_start=%b, required col_sel=%b row_n=%b frame_start=%b",
                         cyc, bus.col_sel, bus.row_n, bus.frame_start, m.col, m.row, m.fs);
            end
        end
    end

    // Watchdog against a stuck run.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within the time limit");
        $fatal(1);
    end

    initial begin
        int b;
        int d;
        int f;
`ifdef MATRIX_BLINK_EN
        blink_en = 1'b1;
`else
        blink_en = 1'b0;
`endif
        rst_n      = 1'b1;
        bus.enable = 1'b1;
        bus.state  = 2'b10;
        bus.blink  = 1'b0;
        #1 rst_n = 1'b0;
        @(negedge clk);

        // Reset state: pins blank, no frame pulse.
        push_blank(cyc + 1, cyc + 3);
        wait_to(cyc + 3);

        // Release reset with aspersao; frame 1 starts on the next edge.
        rst_n = 1'b1;
        b = cyc + 1;
        push_frame(b, 2, 1'b0);
        push_frame(b + 40, 2, 1'b0);
        push_frame(b + 80, 1, 1'b0);

        // No tearing: switch to gotejamento while column 2 of frame 2 is lit.
        wait_to(b + 58);
        bus.state = 2'b01;

        // Undefined state requested during frame 3, shown from frame 4.
        wait_to(b + 90);
        bus.state = 2'b11;
        push_frame(b + 120, 3, 1'b0);
        wait_to(b + 130);
        bus.state = 2'b10;

        // Enable drop at column 1, slot cycle 4 of frame 5.
        b = b + 160;
        d = b + 12;
        push_range(b, 2, 1'b0, 0, 12);
        push_blank(d + 1, d + 6);
        wait_to(d);
        bus.enable = 1'b0;
        wait_to(d + 6);
        bus.enable = 1'b1;
        b = d + 7;
        push_frame(b, 2, 1'b0);

        // Blink: two lit frames, two dark (feature built), then lit again.
        wait_to(b + 10);
        bus.blink = 1'b1;
        push_frame(b + 40, 2, 1'b0);
        push_frame(b + 80, 2, 1'b0);
        push_frame(b + 120, 2, blink_en);
        push_frame(b + 160, 2, blink_en);
        push_frame(b + 200, 2, 1'b0);
        wait_to(b + 210);
        bus.blink = 1'b0;
        f = b + 240;
        push_range(f, 2, 1'b0, 0, 29);

        // Async reset at column 3, slot cycle 5.
        wait_to(f + 29);
        push_blank(f + 30, f + 32);
        push_frame(f + 33, 2, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        n_chk++;
        if (bus.col_sel !== 5'b00000 || bus.row_n !== 7'b1111111 || bus.frame_start !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: got col_sel=%b row_n=%b frame_start=%b, required 00000 1111111 0",
                     bus.col_sel, bus.row_n, bus.frame_start);
        end
        wait_to(f + 32);
        rst_n = 1'b1;

        wait_to(f + 75);
        n_chk++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expected samples left unchecked, required 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/matrix_scan_driver.md
# matrix_scan_driver

Time-multiplexed driver for the 5×7 LED status matrix. It converts the irrigation FSM state (idle / gotejamento / aspersao) into a column-scanned drive: one column lit at a time, with a programmable slot period and anti-ghosting blanking. The state is latched only at frame boundaries, so the image never tears. It sits between the irrigation FSM and the matrix pins, and replaces the static per-column pattern outputs.

## Interface
- `CLK_DIV`, default 50000: clock cycles per column slot; must be ≥ 2.
- `DEAD_CYCLES`, default 16: blank cycles at the start of each slot; must satisfy 0 ≤ DEAD_CYCLES < CLK_DIV.
- `BLINK_FRAMES`, default 25: frames on, then frames off, in blink mode (used only with the blink macro).
- `clk` in, 1: system clock.
- `rst_n` in, 1: reset. Asynchronous assert, active-low.
- `enable` in, 1: scan enable.
- `state` in, 2: irrigation FSM state (00 idle, 01 gotejamento, 10 aspersao).
- `blink` in, 1: request blinking of the current image.
- `col_sel` out, MATRIX_COLS: one-hot column drive, active-high.
- `row_n` out, MATRIX_ROWS: row drive, active-low (0 = LED on).
- `frame_start` out, 1: one-cycle pulse when column 0's slot begins.

## Operation
- **Counters**
  - `presc` counts 0..CLK_DIV-1.
  - `col_idx` counts 0..MATRIX_COLS-1. It advances when `presc` wraps, and wraps 4→0.
- **Frame boundary.** A frame boundary is when `col_idx` wraps to 0, and also the first cycle after reset or after `enable` rises. At that cycle:
  - `state_q` ← `state`.
  - `blink_q` ← `blink`.
  - `frame_start` = 1.
  - A mid-frame change of `state` has no visible effect until the next boundary.
- **Per-slot drive**
  - Slot cycles 0..DEAD_CYCLES-1: blank.
  - Remaining cycles: `col_sel` = one-hot(`col_idx`), `row_n` = pattern(`state_q`, `col_idx`).
  - Blank means `col_sel` = 0 and `row_n` = all ones.
- **Patterns** (`row_n` values, for col 0..4)
  - idle: all columns 1111111.
  - aspersao: 0111001, 0011110, 0000000, 0011110, 0111001.
  - gotejamento: 1001111, 0000011, 0000001, 0000011, 1001111.
  - Undefined state 11: idle pattern.
- **Enable low**
  - `presc`, `col_idx` and the frame counter clear synchronously.
  - Outputs are blank and `frame_start` stays 0.
  - When `enable` returns high, the next cycle is a frame boundary, starting at col 0, slot cycle 0.
- **Reset**
  - `presc`, `col_idx` and the frame counter = 0.
  - `state_q` = idle, `blink_q` = 0.
  - `col_sel` = 0, `row_n` = all ones, `frame_start` = 0.
  - Reset asserted mid-slot blanks the outputs immediately (asynchronously).

## Timing
- All outputs are registered. Each output equals the combinational decode of `presc`, `col_idx`, `state_q` and blank, delayed by one clock.
- Slot length is exactly CLK_DIV cycles. Frame length is exactly MATRIX_COLS×CLK_DIV cycles.
- `frame_start` is high for one cycle, aligned with slot cycle 0 of col 0, which is a blank cycle when DEAD_CYCLES > 0.
- With DEAD_CYCLES = 0 there is no blanking, and columns switch back-to-back.
- Latency from `state` change to new image: from 1 up to MATRIX_COLS×CLK_DIV+1 cycles, depending on the frame phase.

## Configuration
- **`MATRIX_BLINK_EN` defined**
  - A frame counter `fcnt` runs over 0..2×BLINK_FRAMES-1 and advances at each frame boundary.
  - When `blink_q` = 1 and `fcnt` ≥ BLINK_FRAMES, the entire frame is blank.
  - `fcnt` clears whenever the frame boundary samples `blink` = 0, so each blink sequence starts with an "on" phase.
- **`MATRIX_BLINK_EN` undefined**
  - The `blink` port exists but is ignored.
  - No frame counter is built and the image is always shown.

## Structure
- Package `matrix_pkg` holds:
  - constants `MATRIX_COLS` = 5 and `MATRIX_ROWS` = 7;
  - the state encodings `ST_IDLE`, `ST_GOTEJAMENTO`, `ST_ASPERSAO`;
  - the function `matrix_pattern(state, col)` returning MATRIX_ROWS bits.
- One sub-module, `matrix_scan_timer`, contains `presc` and `col_idx` and emits the `slot_start`, `blank` and `frame_wrap` strobes.

## Test plan
- **Reset and first frame.** CLK_DIV=8, DEAD_CYCLES=2. Release reset with `state`=10. Required:
  - `frame_start` pulses once;
  - col 0 blank for 2 cycles, then `col_sel`=00001 and `row_n`=0111001 for 6 cycles;
  - col 2 shows `row_n`=0000000.
- **No tearing.** Switch `state` 10→01 during col 2. Required:
  - cols 3 and 4 still show the aspersao patterns;
  - the next col 0 shows 1001111.
- **Undefined state.** `state`=11 → all columns show `row_n`=1111111; `col_sel` keeps scanning.
- **Enable low.** Drop `enable` mid-slot. Required:
  - next cycle `col_sel`=0 and `row_n`=all ones;
  - when `enable` returns, `frame_start` pulses next cycle and the scan restarts at col 0.
- **Blink, MATRIX_BLINK_EN defined.** BLINK_FRAMES=2, `blink`=1. Required: 2 frames imaged, then 2 frames fully blank, repeating. Without the macro, all frames are imaged.
- **Async reset mid-operation.** Assert `rst_n` at col 3, cycle 5. Required: outputs go blank before the next clock edge, and all counters read 0 after release.
